// File: rtl/rob_commit_unit_pkg.sv
// rob_commit_unit_pkg: shared reorder-buffer parameters, which are the same set
// the CDB data controller uses. It also holds the pointer-increment helper.
// Optional feature macro used by the ROB files: ROB_FLUSH_EN.
package rob_commit_unit_pkg;
  localparam int WORD_SIZE = 32;
  localparam int RB_SIZE   = 8;
  localparam int RB_INDEX  = 4;   // RB_SIZE < 2**RB_INDEX so NULL is never a slot
  localparam int REG_INDEX = 5;
  localparam logic [RB_INDEX-1:0] NULL = {RB_INDEX{1'b1}};

  localparam int PTR_W = $clog2(RB_SIZE);
  localparam int CNT_W = $clog2(RB_SIZE + 1);

  // Modulo-RB_SIZE increment. It also works when RB_SIZE is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RB_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction
endpackage

// File: rtl/rob_commit_unit_if.sv
// rob_commit_unit_if: bundles the issue, CDB and commit buses of the ROB.
//   alloc_*  : issue request (in) / granted index and full flag (out)
//   CDB_*    : per-slot flattened result, valid and store-address vectors (in)
//   commit_* : in-order retire handshake toward the architectural state
//   flush    : discard everything (only when ROB_FLUSH_EN is defined)
// The slave modport is the ROB side. The master modport is the driver side.
interface rob_commit_unit_if;
  import rob_commit_unit_pkg::*;
  logic                          alloc_valid;
  logic [REG_INDEX-1:0]          alloc_dest;
  logic                          alloc_is_store;
  logic [RB_INDEX-1:0]           alloc_index;
  logic                          full;
  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data;
  logic [RB_SIZE-1:0]            CDB_data_valid;
  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_addr;
  logic                          commit_valid;
  logic                          commit_ready;
  logic [REG_INDEX-1:0]          commit_dest;
  logic [WORD_SIZE-1:0]          commit_data;
  logic [WORD_SIZE-1:0]          commit_addr;
  logic                          commit_is_store;
`ifdef ROB_FLUSH_EN
  logic                          flush;
`endif

  modport slave (
`ifdef ROB_FLUSH_EN
    input  flush,
`endif
    input  alloc_valid, alloc_dest, alloc_is_store,
    input  CDB_data_data, CDB_data_valid, CDB_data_addr, commit_ready,
    output alloc_index, full,
    output commit_valid, commit_dest, commit_data, commit_addr, commit_is_store
  );

  modport master (
`ifdef ROB_FLUSH_EN
    output flush,
`endif
    output alloc_valid, alloc_dest, alloc_is_store,
    output CDB_data_data, CDB_data_valid, CDB_data_addr, commit_ready,
    input  alloc_index, full,
    input  commit_valid, commit_dest, commit_data, commit_addr, commit_is_store
  );
endinterface

// File: rtl/rob_commit_unit_entry.sv
// rob_entry: storage for one reorder-buffer slot.
//   clr   : pop or flush. It drops busy/done and has priority over alloc and capture.
//   alloc : claim the slot. It sets busy, clears done and loads dest/is_store.
//   cap   : CDB result for this slot. It is taken only while the slot is already busy.
//   outputs: registered busy/done/is_store/dest/data/addr
module rob_entry
  import rob_commit_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 alloc,
  input  logic [REG_INDEX-1:0] alloc_dest,
  input  logic                 alloc_is_store,
  input  logic                 cap,
  input  logic [WORD_SIZE-1:0] cap_data,
  input  logic [WORD_SIZE-1:0] cap_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 is_store,
  output logic [REG_INDEX-1:0] dest,
  output logic [WORD_SIZE-1:0] data,
  output logic [WORD_SIZE-1:0] addr
);
  logic                 busy_q, busy_d, done_q, done_d, st_q, st_d;
  logic [REG_INDEX-1:0] dest_q, dest_d;
  logic [WORD_SIZE-1:0] data_q, data_d, addr_q, addr_d;

  always_comb begin
    busy_d = busy_q; done_d = done_q; st_d = st_q;
    dest_d = dest_q; data_d = data_q; addr_d = addr_q;
    if (clr) begin
      busy_d = 1'b0;
      done_d = 1'b0;
    end else if (alloc) begin
      // A slot being allocated is not busy yet, so a same-cycle CDB write is dropped.
      busy_d = 1'b1;
      done_d = 1'b0;
      dest_d = alloc_dest;
      st_d   = alloc_is_store;
    end else if (cap && busy_q) begin
      done_d = 1'b1;
      data_d = cap_data;
      addr_d = cap_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0; done_q <= 1'b0; st_q <= 1'b0;
      dest_q <= '0;   data_q <= '0;   addr_q <= '0;
    end else begin
      busy_q <= busy_d; done_q <= done_d; st_q <= st_d;
      dest_q <= dest_d; data_q <= data_d; addr_q <= addr_d;
    end
  end

  assign busy = busy_q; assign done = done_q; assign is_store = st_q;
  assign dest = dest_q; assign data = data_q; assign addr = addr_q;
endmodule

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: reorder buffer with in-order commit.
// Ports: clk, reset (synchronous, active high), and bus (rob_commit_unit_if.slave).
// The bus carries issue allocation, the per-slot CDB capture vectors and the commit handshake.
// Optional feature: define ROB_FLUSH_EN to add bus.flush, which empties the buffer.
// It has priority below reset and above allocate, capture and commit.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  rob_commit_unit_if.slave bus
);
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flush_w, full, alloc_fire, commit_valid, pop;

  logic [RB_SIZE-1:0]                busy, done, is_store, ent_clr, ent_alloc;
  logic [RB_SIZE-1:0][REG_INDEX-1:0] dest;
  logic [RB_SIZE-1:0][WORD_SIZE-1:0] data, addr;

`ifdef ROB_FLUSH_EN
  assign flush_w = bus.flush;
`else
  assign flush_w = 1'b0;
`endif

  // full uses the pre-edge count, so a same-cycle pop cannot make room for an allocation.
  assign full         = (count_q == CNT_W'(RB_SIZE));
  assign alloc_fire   = bus.alloc_valid && !full && !flush_w;
  assign commit_valid = busy[head_q] && done[head_q];
  assign pop          = commit_valid && bus.commit_ready && !flush_w;

  assign bus.full            = full;
  assign bus.alloc_index     = full ? NULL : RB_INDEX'(tail_q);
  assign bus.commit_valid    = commit_valid;
  assign bus.commit_dest     = dest[head_q];
  assign bus.commit_data     = data[head_q];
  assign bus.commit_addr     = addr[head_q];
  assign bus.commit_is_store = is_store[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_w) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_fire) tail_d = ptr_inc(tail_q);
      if (pop)        head_d = ptr_inc(head_q);
      case ({alloc_fire, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  for (genvar k = 0; k < RB_SIZE; k++) begin : g_ent
    // A pop clears the head slot. This beats a same-cycle CDB write to that slot.
    assign ent_clr[k]   = flush_w || (pop && head_q == PTR_W'(k));
    assign ent_alloc[k] = alloc_fire && tail_q == PTR_W'(k);

    rob_entry u_entry (
      .clk           (clk),
      .reset         (reset),
      .clr           (ent_clr[k]),
      .alloc         (ent_alloc[k]),
      .alloc_dest    (bus.alloc_dest),
      .alloc_is_store(bus.alloc_is_store),
      .cap           (bus.CDB_data_valid[k]),
      .cap_data      (bus.CDB_data_data[k*WORD_SIZE +: WORD_SIZE]),
      .cap_addr      (bus.CDB_data_addr[k*WORD_SIZE +: WORD_SIZE]),
      .busy          (busy[k]),
      .done          (done[k]),
      .is_store      (is_store[k]),
      .dest          (dest[k]),
      .data          (data[k]),
      .addr          (addr[k])
    );
  end
endmodule

// File: tb/tb_rob_commit_unit.sv
// Testbench for rob_commit_unit. It runs directed scenarios and a randomized stream.
// Results are checked against a program-order queue model of the reorder buffer.
module tb_rob_commit_unit;
  import rob_commit_unit_pkg::*;

  logic clk = 1'b0;
  logic reset, fl;
  int   n_cmp, n_bad;

  rob_commit_unit_if bus();
  rob_commit_unit dut (.clk(clk), .reset(reset), .bus(bus));
`ifdef ROB_FLUSH_EN
  assign bus.flush = fl;
`endif

  always #5 clk = ~clk;

  // Reference model: in-flight instructions oldest first, plus the next slot to hand out.
  typedef struct {
    int                   slot;
    logic [REG_INDEX-1:0] dest;
    logic                 st;
    logic                 done;
    logic [WORD_SIZE-1:0] data;
    logic [WORD_SIZE-1:0] addr;
  } ment_t;
  ment_t q[$];
  int    m_tail;

  function automatic logic e_full();
    return q.size() == RB_SIZE;
  endfunction
  function automatic logic [RB_INDEX-1:0] e_idx();
    return (q.size() == RB_SIZE) ? NULL : RB_INDEX'(m_tail);
  endfunction
  function automatic logic e_valid();
    return (q.size() > 0) && q[0].done;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven on the bus.
  task automatic tick();
    logic full_pre, pop;
    @(posedge clk);
    full_pre = e_full();
    pop      = e_valid() && bus.commit_ready;
    if (reset || fl) begin
      q.delete();
      m_tail = 0;
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        ment_t e = q[i];
        if (bus.CDB_data_valid[e.slot]) begin
          e.done = 1'b1;
          e.data = bus.CDB_data_data[e.slot*WORD_SIZE +: WORD_SIZE];
          e.addr = bus.CDB_data_addr[e.slot*WORD_SIZE +: WORD_SIZE];
          q[i] = e;
        end
      end
      if (pop) void'(q.pop_front());
      if (bus.alloc_valid && !full_pre) begin
        q.push_back('{m_tail, bus.alloc_dest, bus.alloc_is_store, 1'b0, '0, '0});
        m_tail = (m_tail + 1) % RB_SIZE;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0; bus.alloc_dest = '0; bus.alloc_is_store = 1'b0;
    bus.CDB_data_valid = '0; bus.CDB_data_data = '0; bus.CDB_data_addr = '0;
    bus.commit_ready = 1'b0; fl = 1'b0;
  endtask

  task automatic set_cdb(input int k, input logic [WORD_SIZE-1:0] d, input logic [WORD_SIZE-1:0] a);
    bus.CDB_data_data[k*WORD_SIZE +: WORD_SIZE] = d;
    bus.CDB_data_addr[k*WORD_SIZE +: WORD_SIZE] = a;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %0b want 0", bus.full); end
    n_cmp++; if (bus.alloc_index !== 4'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", bus.alloc_index); end
    n_cmp++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cvalid: got %0b want 0", bus.commit_valid); end
    n_cmp++; if (bus.commit_dest !== 5'd0) begin n_bad++; $display("FAIL reset_dest: got %0d want 0", bus.commit_dest); end
    n_cmp++; if (bus.commit_data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.commit_data); end
    n_cmp++; if (bus.commit_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus.commit_addr); end
    n_cmp++; if (bus.commit_is_store !== 1'b0) begin n_bad++; $display("FAIL reset_st: got %0b want 0", bus.commit_is_store); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.alloc_valid = 1'b1; bus.alloc_dest = 5'(i + 1);
      n_cmp++; if (bus.alloc_index !== 4'(i)) begin n_bad++; $display("FAIL basic_idx%0d: got %0d want %0d", i, bus.alloc_index, i); end
      tick();
    end
    idle(); bus.CDB_data_valid = 8'b010; set_cdb(1, 32'h22, 32'h0); tick(); idle();
    n_cmp++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL basic_ooo: got %0b want 0", bus.commit_valid); end
    bus.CDB_data_valid = 8'b001; set_cdb(0, 32'h11, 32'h0); tick(); idle();
    n_cmp++; if ({bus.commit_valid, bus.commit_dest, bus.commit_data} !== {1'b1, 5'd1, 32'h11}) begin
      n_bad++; $display("FAIL basic_c1: got v%0b d%0d %h want v1 d1 11", bus.commit_valid, bus.commit_dest, bus.commit_data); end
    bus.commit_ready = 1'b1; tick();
    n_cmp++; if ({bus.commit_valid, bus.commit_dest, bus.commit_data} !== {1'b1, 5'd2, 32'h22}) begin
      n_bad++; $display("FAIL basic_c2: got v%0b d%0d %h want v1 d2 22", bus.commit_valid, bus.commit_dest, bus.commit_data); end
    tick();
    n_cmp++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL basic_c3: got %0b want 0", bus.commit_valid); end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < RB_SIZE; i++) begin bus.alloc_valid = 1'b1; bus.alloc_dest = 5'($urandom); tick(); end
    idle();
    n_cmp++; if ({bus.full, bus.alloc_index} !== {1'b1, NULL}) begin n_bad++; $display("FAIL full_set: got f%0b i%0d want f1 i15", bus.full, bus.alloc_index); end
    bus.CDB_data_valid = 8'b1; tick(); idle();
    bus.alloc_valid = 1'b1; bus.commit_ready = 1'b1; tick(); idle();
    n_cmp++; if ({bus.full, bus.alloc_index, bus.commit_valid} !== {1'b0, 4'd0, 1'b0}) begin
      n_bad++; $display("FAIL full_rej: got f%0b i%0d v%0b want f0 i0 v0", bus.full, bus.alloc_index, bus.commit_valid); end
    bus.alloc_valid = 1'b1; tick(); idle();
    n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL full_refill: got %0b want 1", bus.full); end
  endtask

  task automatic test_nonbusy();
    do_reset();
    for (int i = 0; i < 5; i++) begin bus.alloc_valid = 1'b1; bus.alloc_dest = 5'(10 + i); tick(); end
    idle(); bus.CDB_data_valid = 8'h20; set_cdb(5, 32'hDEAD, 32'hBEEF); tick();
    bus.CDB_data_valid = 8'h20; bus.alloc_valid = 1'b1; bus.alloc_dest = 5'd20;
    n_cmp++; if (bus.alloc_index !== 4'd5) begin n_bad++; $display("FAIL nb_idx: got %0d want 5", bus.alloc_index); end
    tick(); idle();
    bus.CDB_data_valid = 8'h1F; tick(); idle(); bus.commit_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({bus.commit_valid, bus.commit_dest} !== {1'b1, 5'(10 + i)}) begin
        n_bad++; $display("FAIL nb_pop%0d: got v%0b d%0d want v1 d%0d", i, bus.commit_valid, bus.commit_dest, 10 + i); end
      tick();
    end
    n_cmp++; if ({bus.commit_valid, bus.commit_dest} !== {1'b0, 5'd20}) begin
      n_bad++; $display("FAIL nb_slot5: got v%0b d%0d want v0 d20", bus.commit_valid, bus.commit_dest); end
    idle();
  endtask

  task automatic test_store();
    do_reset();
    bus.alloc_valid = 1'b1; bus.alloc_is_store = 1'b1; bus.alloc_dest = 5'd7; tick(); idle();
    bus.CDB_data_valid = 8'b1; set_cdb(0, 32'h5, 32'h1000); tick(); idle();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({bus.commit_valid, bus.commit_is_store, bus.commit_addr, bus.commit_data, bus.commit_dest} !==
                   {1'b1, 1'b1, 32'h1000, 32'h5, 5'd7}) begin
        n_bad++; $display("FAIL store_hold%0d: got v%0b s%0b a%h d%h r%0d want v1 s1 a1000 d5 r7", i,
                          bus.commit_valid, bus.commit_is_store, bus.commit_addr, bus.commit_data, bus.commit_dest); end
      tick();
    end
    bus.commit_ready = 1'b1; bus.CDB_data_valid = 8'b1; set_cdb(0, 32'h99, 32'h0); tick(); idle();
    n_cmp++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL store_pop: got %0b want 0", bus.commit_valid); end
  endtask

  task automatic test_random();
    int commits = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.alloc_valid    = ($urandom_range(0, 99) < 60);
      bus.alloc_dest     = 5'($urandom);
      bus.alloc_is_store = 1'($urandom);
      bus.CDB_data_valid = 8'($urandom) & 8'($urandom);
      for (int k = 0; k < RB_SIZE; k++) set_cdb(k, $urandom, $urandom);
      bus.commit_ready   = ($urandom_range(0, 99) < 70);
      reset = (c == 200);
      n_cmp++; if ({bus.full, bus.alloc_index, bus.commit_valid} !== {e_full(), e_idx(), e_valid()}) begin
        n_bad++; $display("FAIL rnd_ctl@%0d: got f%0b i%0d v%0b want f%0b i%0d v%0b", c, bus.full, bus.alloc_index,
                          bus.commit_valid, e_full(), e_idx(), e_valid()); end
      if (e_valid()) begin
        n_cmp++; if ({bus.commit_dest, bus.commit_data, bus.commit_addr, bus.commit_is_store} !==
                     {q[0].dest, q[0].data, q[0].addr, q[0].st}) begin
          n_bad++; $display("FAIL rnd_head@%0d: got r%0d d%h a%h s%0b want r%0d d%h a%h s%0b", c, bus.commit_dest,
                            bus.commit_data, bus.commit_addr, bus.commit_is_store, q[0].dest, q[0].data, q[0].addr, q[0].st); end
        if (bus.commit_ready && !reset) commits++;
      end
      tick();
    end
    reset = 1'b0;
    idle(); bus.CDB_data_valid = '1; bus.commit_ready = 1'b1;
    for (int c = 0; c < 30 && q.size() > 0; c++) tick();
    idle();
    n_cmp++; if ({bus.commit_valid, bus.full, bus.alloc_index} !== {1'b0, 1'b0, e_idx()} || q.size() != 0) begin
      n_bad++; $display("FAIL rnd_drain: got v%0b f%0b i%0d left %0d want v0 f0 i%0d left 0", bus.commit_valid,
                        bus.full, bus.alloc_index, q.size(), e_idx()); end
    n_cmp++; if (commits < 20) begin n_bad++; $display("FAIL rnd_commits: got %0d want >=20", commits); end
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin bus.alloc_valid = 1'b1; bus.alloc_dest = 5'(i); tick(); end
    idle(); bus.CDB_data_valid = 8'h3; tick(); idle();
    fl = 1'b1; bus.alloc_valid = 1'b1; bus.CDB_data_valid = '1; bus.commit_ready = 1'b1; tick(); idle();
    n_cmp++; if ({bus.commit_valid, bus.full, bus.alloc_index} !== {1'b0, 1'b0, 4'd0}) begin
      n_bad++; $display("FAIL flush: got v%0b f%0b i%0d want v0 f0 i0", bus.commit_valid, bus.full, bus.alloc_index); end
  endtask
`endif

  initial begin
    n_cmp = 0; n_bad = 0; m_tail = 0; reset = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_nonbusy();
    test_store();
    test_random();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
